// File: rtl/jt49_cmd_seq.sv
// jt49_cmd_seq: command-list sequencer that plays register writes onto a jt49
// PSG bus, with timed waits, END/loop handling and start/stop control.
module jt49_cmd_seq #(
    parameter  int DEPTH   = 64,
    parameter  int CHIPW   = 1,
    parameter  int WAIT_SH = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = 12 + CHIPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             ld_we,
    input  logic [AW-1:0]    ld_addr,
    input  logic [CW-1:0]    ld_data,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    pc,
    output logic [3:0]       psg_addr,
    output logic [7:0]       psg_dout,
    output logic [CHIPW-1:0] psg_sel,
    output logic             psg_wr_n
);

    localparam int          CNTW    = 8 + WAIT_SH;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
    localparam logic [3:0]  OP_END  = 4'hE;
    localparam logic [3:0]  OP_WAIT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT
    } state_t;

    state_t            state, state_n;
    logic [AW-1:0]     pc_n;
    logic [CNTW-1:0]   cnt, cnt_n;
    logic [3:0]        addr_n;
    logic [7:0]        dout_n;
    logic [CHIPW-1:0]  sel_n;
    logic              wr_n_n;
    logic              done_n;
    logic              advance;
    logic              finish;

    logic [CW-1:0]     mem [DEPTH];
    logic [CW-1:0]     rd_data;

    logic [3:0]        op;
    logic [7:0]        arg;
    logic [CHIPW-1:0]  chip;
    logic [CNTW-1:0]   wait_len;

    assign op       = rd_data[11:8];
    assign arg      = rd_data[7:0];
    assign chip     = rd_data[CW-1:12];
    assign wait_len = CNTW'(arg) << WAIT_SH;
    assign busy     = (state != S_IDLE);

    // Command store: host loads only while idle; slot pc is read back every clock.
    always_ff @(posedge clk) begin
        if (ld_we && state == S_IDLE)
            mem[ld_addr] <= ld_data;
        rd_data <= mem[pc];
    end

    // Next-state and bus outputs; stop overrides everything, all else waits on cen.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        addr_n  = psg_addr;
        dout_n  = psg_dout;
        sel_n   = psg_sel;
        wr_n_n  = 1'b1;
        done_n  = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        if (stop) begin
            state_n = S_IDLE;
        end else if (cen) begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n = S_FETCH;
                        pc_n    = '0;
                    end
                end
                S_FETCH: state_n = S_EXEC;
                S_EXEC: begin
                    if (op == OP_END) begin
                        finish = 1'b1;
                    end else if (op == OP_WAIT) begin
                        // The WAIT command occupies wait_len ticks in total,
                        // its own fetch and exec ticks included.
                        if (wait_len > CNTW'(2)) begin
                            cnt_n   = wait_len;
                            state_n = S_WAIT;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        addr_n  = op;
                        dout_n  = arg;
                        sel_n   = chip;
                        wr_n_n  = 1'b0;
                        advance = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt <= CNTW'(3))
                        advance = 1'b1;
                    else
                        cnt_n = cnt - CNTW'(1);
                end
                default: state_n = S_IDLE;
            endcase
            if (advance) begin
                if (pc == LAST) begin
                    finish = 1'b1;
                end else begin
                    pc_n    = pc + AW'(1);
                    state_n = S_FETCH;
                end
            end
            if (finish) begin
                if (loop_en) begin
                    pc_n    = '0;
                    state_n = S_FETCH;
                end else begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
        end
    end

    // State and output registers; wr_n and done self-clear every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            cnt      <= '0;
            psg_addr <= '0;
            psg_dout <= '0;
            psg_sel  <= '0;
            psg_wr_n <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            cnt      <= cnt_n;
            psg_addr <= addr_n;
            psg_dout <= dout_n;
            psg_sel  <= sel_n;
            psg_wr_n <= wr_n_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_jt49_cmd_seq.sv
// tb_jt49_cmd_seq: scoreboard bench; a list-level model predicts each PSG write
// and done pulse with its cen-tick time, a monitor matches the DUT against it.
module tb_jt49_cmd_seq;

    localparam int DEPTH   = 4;
    localparam int CHIPW   = 1;
    localparam int WAIT_SH = 8;
    localparam int AW      = 2;
    localparam int CW      = 13;
    localparam int BUDGET  = 10000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cen = 1'b0;
    logic             ld_we = 1'b0;
    logic [AW-1:0]    ld_addr = '0;
    logic [CW-1:0]    ld_data = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
    logic             busy;
    logic             done;
    logic [AW-1:0]    pc;
    logic [3:0]       psg_addr;
    logic [7:0]       psg_dout;
    logic [CHIPW-1:0] psg_sel;
    logic             psg_wr_n;

    jt49_cmd_seq #(.DEPTH(DEPTH), .CHIPW(CHIPW), .WAIT_SH(WAIT_SH)) dut (
        .clk(clk), .rst(rst), .cen(cen), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start), .stop(stop), .loop_en(loop_en),
        .busy(busy), .done(done), .pc(pc), .psg_addr(psg_addr),
        .psg_dout(psg_dout), .psg_sel(psg_sel), .psg_wr_n(psg_wr_n)
    );

    typedef struct {
        bit               is_done;
        logic [3:0]       a;
        logic [7:0]       d;
        logic [CHIPW-1:0] s;
        int               t;
    } ev_t;

    ev_t           q[$];
    logic [CW-1:0] prog [DEPTH];
    int            checks = 0;
    int            errors = 0;
    int            tick = 0;
    int            base = 0;
    int            cen_per = 1;
    int            phase = 0;
    bit            prev_low = 1'b0;

    initial forever #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // cen pattern generator and cen-tick counter
    initial forever begin
        @(posedge clk);
        if (cen) tick++;
        #1;
        phase++;
        cen = ((phase % cen_per) == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every bus write and done pulse is matched against the queue head.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_low = 1'b0;
                continue;
            end
            if (!psg_wr_n) begin
                check("wr_width", 32'(prev_low), 32'd0);
                if (q.size() == 0 || q[0].is_done) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h sel %0h tick %0d, expected no write",
                             psg_addr, psg_dout, psg_sel, tick - base);
                end else begin
                    e = q.pop_front();
                    check("wr_addr", 32'(psg_addr), 32'(e.a));
                    check("wr_data", 32'(psg_dout), 32'(e.d));
                    check("wr_sel",  32'(psg_sel),  32'(e.s));
                    check("wr_tick", tick - base, e.t);
                end
            end
            prev_low = !psg_wr_n;
            if (done) begin
                if (q.size() == 0 || !q[0].is_done) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: tick %0d, expected no done pulse", tick - base);
                end else begin
                    e = q.pop_front();
                    check("done_tick", tick - base, e.t);
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
        end
    end

    // Reference model: each command costs 2 cen ticks, a WAIT N>0 costs
    // max(2, N<<WAIT_SH); writes land on the last tick of their command.
    task automatic build(input bit lp, input int maxw, output int pc_end);
        int         t = 0;
        int         s = 0;
        int         nw = 0;
        int         cost;
        ev_t        e;
        logic [3:0] op;
        logic [7:0] d;
        pc_end = 0;
        for (int guard = 0; guard < 1000; guard++) begin
            op = prog[s][11:8];
            d  = prog[s][7:0];
            if (op < 4'hE) begin
                t += 2;
                e.is_done = 1'b0;
                e.a = op;
                e.d = d;
                e.s = prog[s][CW-1:12];
                e.t = t;
                q.push_back(e);
                nw++;
                if (lp && nw >= maxw) begin
                    pc_end = (s + 1) % DEPTH;
                    return;
                end
            end else if (op == 4'hF) begin
                cost = int'(d) << WAIT_SH;
                t += (cost > 2) ? cost : 2;
            end else begin
                t += 2;
            end
            if (op == 4'hE || s == DEPTH - 1) begin
                if (lp) begin
                    s = 0;
                end else begin
                    e.is_done = 1'b1;
                    e.a = '0;
                    e.d = '0;
                    e.s = '0;
                    e.t = t;
                    q.push_back(e);
                    pc_end = s;
                    return;
                end
            end else begin
                s++;
            end
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < DEPTH; i++) begin
            ld_we   = 1'b1;
            ld_addr = AW'(i);
            ld_data = prog[i];
            @(posedge clk);
            #1;
        end
        ld_we = 1'b0;
    endtask

    task automatic run(input bit lp, input int maxw, input int per);
        int pc_exp;
        int n;
        cen_per = per;
        loop_en = lp;
        load_prog();
        build(lp, maxw, pc_exp);
        start = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            if (cen) break;
            n++;
        end
        #1;
        start = 1'b0;
        base  = tick;
        // load attempt while busy must not alter the running list
        ld_we   = 1'b1;
        ld_addr = AW'($urandom_range(1, DEPTH - 1));
        ld_data = {1'b1, 4'hD, 8'h5A};
        @(posedge clk);
        #1;
        ld_we = 1'b0;
        n = 0;
        while ((q.size() != 0 || (!lp && busy)) && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        check("drain_in_budget", 32'(q.size()), 32'd0);
        q.delete();
        if (lp) begin
            #1;
            stop = 1'b1;
            @(posedge clk);
            #1;
            stop = 1'b0;
            check("busy_after_stop", 32'(busy), 32'd0);
            check("wr_n_after_stop", 32'(psg_wr_n), 32'd1);
            check("pc_after_stop", 32'(pc), 32'(pc_exp));
            repeat (3 * per + 4) @(posedge clk);
            #1;
        end else begin
            #1;
            check("pc_at_end", 32'(pc), 32'(pc_exp));
            check("busy_at_end", 32'(busy), 32'd0);
        end
    endtask

    function automatic logic [CW-1:0] rnd_cmd();
        int         r;
        logic [3:0] op;
        logic [7:0] d;
        r = $urandom_range(0, 99);
        d = 8'($urandom_range(0, 255));
        if (r < 70) begin
            op = 4'($urandom_range(0, 13));
        end else if (r < 85) begin
            op = 4'hF;
            d  = 8'($urandom_range(0, 1));
        end else begin
            op = 4'hE;
        end
        return {1'($urandom_range(0, 1)), op, d};
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_wr_n", 32'(psg_wr_n), 32'd1);
        check("rst_addr", 32'(psg_addr), 32'd0);
        check("rst_dout", 32'(psg_dout), 32'd0);
        check("rst_sel", 32'(psg_sel), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        prog[0] = {1'b0, 4'h0, 8'h01};
        prog[1] = {1'b0, 4'h1, 8'h00};
        prog[2] = {1'b0, 4'hE, 8'h00};
        prog[3] = {1'b0, 4'hE, 8'h00};
        run(1'b0, 0, 1);
        run(1'b0, 0, 4);

        prog[0] = {1'b0, 4'h0, 8'h11};
        prog[1] = {1'b0, 4'hF, 8'h03};
        prog[2] = {1'b0, 4'h1, 8'h22};
        prog[3] = {1'b0, 4'hE, 8'h00};
        run(1'b0, 0, 1);

        prog[0] = {1'b0, 4'h0, 8'hAA};
        prog[1] = {1'b1, 4'h1, 8'hBB};
        prog[2] = {1'b0, 4'hE, 8'h00};
        prog[3] = {1'b0, 4'h7, 8'h00};
        run(1'b1, 6, 1);

        prog[0] = {1'b0, 4'h2, 8'h10};
        prog[1] = {1'b1, 4'h3, 8'h20};
        prog[2] = {1'b0, 4'h4, 8'h30};
        prog[3] = {1'b1, 4'h5, 8'h40};
        run(1'b0, 0, 1);
        run(1'b1, 7, 2);

        for (int k = 0; k < 16; k++) begin
            bit lp;
            lp = 1'($urandom_range(0, 1));
            for (int i = 0; i < DEPTH; i++) prog[i] = rnd_cmd();
            if (lp) prog[0] = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 13)), 8'($urandom_range(0, 255))};
            run(lp, $urandom_range(2, 4), $urandom_range(1, 2));
        end

        // reset in the middle of a long wait aborts playback
        prog[0] = {1'b0, 4'hF, 8'h01};
        prog[1] = {1'b0, 4'h6, 8'h66};
        prog[2] = {1'b0, 4'hE, 8'h00};
        prog[3] = {1'b0, 4'hE, 8'h00};
        cen_per = 1;
        loop_en = 1'b0;
        load_prog();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pc", 32'(pc), 32'd0);
        check("midrst_wr_n", 32'(psg_wr_n), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("midrst_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
